// File: rtl/sync_pkg.sv
// Shared types and helpers for the synchronized-input filtering blocks.
package sync_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    QUAL_HIGH = 2'd1,
    HIGH      = 2'd2,
    QUAL_LOW  = 2'd3
  } filt_state_t;

  // Bits needed to hold a stability count of 0..max_val (at least one bit).
  function automatic int stab_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_edge_filter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment in the
// same cycle leaves the counter at one.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count register: reset, clear-then-count, or saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sync_edge_filter.sv
// Level qualification filter for an already-synchronized input.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LOW       | q=0 accepted, input currently matches
// QUAL_HIGH | q=0 accepted, input high; counting consecutive high samples
// HIGH      | q=1 accepted, input currently matches
// QUAL_LOW  | q=1 accepted, input low; counting consecutive low samples
module sync_edge_filter
  import sync_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_sync,
  input  logic             en,
  input  logic             cnt_clr,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int STAB_W = stab_width(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  filt_state_t       state, state_n;
  logic [STAB_W-1:0] stab_cnt, stab_n;
  logic              q_n, rise_n, fall_n;

  // State, stability count and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOW;
      stab_cnt <= '0;
      q        <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      state    <= state_n;
      stab_cnt <= stab_n;
      q        <= q_n;
      rise     <= rise_n;
      fall     <= fall_n;
    end
  end

  // Next-state logic; with en low everything holds and no pulse is produced.
  always_comb begin
    state_n = state;
    stab_n  = stab_cnt;
    q_n     = q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (en) begin
      case (state)
        LOW: begin
          if (d_sync) begin
            if (STABLE_CYCLES == 1) begin
              state_n = HIGH;
              stab_n  = '0;
              q_n     = 1'b1;
              rise_n  = 1'b1;
            end else begin
              state_n = QUAL_HIGH;
              stab_n  = STAB_W'(1);
            end
          end
        end
        QUAL_HIGH: begin
          if (d_sync) begin
            if (stab_cnt == STAB_LAST) begin
              state_n = HIGH;
              stab_n  = '0;
              q_n     = 1'b1;
              rise_n  = 1'b1;
            end else begin
              stab_n = stab_cnt + STAB_W'(1);
            end
          end else begin
            state_n = LOW;
            stab_n  = '0;
          end
        end
        HIGH: begin
          if (!d_sync) begin
            if (STABLE_CYCLES == 1) begin
              state_n = LOW;
              stab_n  = '0;
              q_n     = 1'b0;
              fall_n  = 1'b1;
            end else begin
              state_n = QUAL_LOW;
              stab_n  = STAB_W'(1);
            end
          end
        end
        QUAL_LOW: begin
          if (!d_sync) begin
            if (stab_cnt == STAB_LAST) begin
              state_n = LOW;
              stab_n  = '0;
              q_n     = 1'b0;
              fall_n  = 1'b1;
            end else begin
              stab_n = stab_cnt + STAB_W'(1);
            end
          end else begin
            state_n = HIGH;
            stab_n  = '0;
          end
        end
        default: begin
          state_n = LOW;
          stab_n  = '0;
        end
      endcase
    end
  end

  // Accepted-edge counter advances on the same edge the pulse is registered.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_edge_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rise_n | fall_n),
    .clr (cnt_clr),
    .cnt (edge_cnt)
  );

endmodule

// File: doc/sync_edge_filter.md
# sync_edge_filter

Sits downstream of the two-flop synchronizer and consumes its already-synchronized output. A qualification FSM filters that level: a new level is accepted only after it has been sampled stable for `STABLE_CYCLES` consecutive enabled cycles. The block then produces a clean filtered level, single-cycle rise and fall pulses, and a saturating count of accepted edges. It gives destination-domain logic glitch-free events from a noisy or bouncing crossed signal.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required to accept a new level; legal range 1..255.
- `CNT_W`, 8: width of the accepted-edge counter; minimum 1.

- `clk`  in  1: sole clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `d_sync`  in  1: synchronized input level from the upstream synchronizer; treated as clean in `clk` domain.
- `en`  in  1: sample enable; when low the block is frozen.
- `cnt_clr`  in  1: synchronous clear of `edge_cnt`.
- `q`  out  1: filtered level, registered.
- `rise`  out  1: one-cycle pulse when `q` goes 0→1, registered.
- `fall`  out  1: one-cycle pulse when `q` goes 1→0, registered.
- `edge_cnt`  out  `CNT_W`: accepted edges (rise + fall), saturating at all-ones.

## Operation
- FSM states: `LOW`, `QUAL_HIGH`, `HIGH`, `QUAL_LOW`. Stability counter `stab_cnt` is sized for values 0..`STABLE_CYCLES`.
- `LOW`:
  - `d_sync`=1 → `QUAL_HIGH` with `stab_cnt`=1.
  - If `STABLE_CYCLES`=1, go directly to `HIGH` instead.
- `QUAL_HIGH`:
  - `d_sync`=1 with `stab_cnt`=`STABLE_CYCLES`-1 → `HIGH`; `q`←1, `rise`←1.
  - `d_sync`=1 otherwise → `stab_cnt`++.
  - `d_sync`=0 → `LOW`, `stab_cnt`←0; no pulse, `q` unchanged.
- `HIGH` and `QUAL_LOW` mirror `LOW` and `QUAL_HIGH` with polarity inverted; acceptance sets `q`←0 and `fall`←1.
- `rise` and `fall` are high for exactly one cycle and are never high together.
- `edge_cnt`:
  - Increments on every cycle `rise` or `fall` is asserted.
  - Holds at 2^`CNT_W`-1 once reached; never wraps.
  - `cnt_clr` alone → 0.
  - `cnt_clr` coincident with an accepted edge → 1 (clear, then count).
- `en`=0:
  - State, `stab_cnt`, `q` and `edge_cnt` hold.
  - `rise`=`fall`=0.
  - `cnt_clr` still acts.
  - Qualification resumes from the held `stab_cnt` when `en` returns.
- Reset (dominant over `en` and `cnt_clr`, any state):
  - State `LOW`, `stab_cnt`=0, `q`=0, `rise`=0, `fall`=0, `edge_cnt`=0.
  - A qualification in progress is discarded.

## Timing
- Latency from the first enabled cycle sampling a new level to the `q` change and edge pulse: `STABLE_CYCLES` cycles. Both become visible after the edge that samples the `STABLE_CYCLES`-th consecutive value.
- `edge_cnt` updates on the same edge as the pulse.
- Any pulse shorter than `STABLE_CYCLES` enabled cycles is fully suppressed: no `q` change, no pulse, no count.
- Once a level is accepted, the next opposite edge needs at least `STABLE_CYCLES` further cycles. Maximum edge rate is therefore one per `STABLE_CYCLES` cycles.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package `sync_pkg`:
  - State enum `filt_state_t` with the four states.
  - Helper function for the `stab_cnt` width.
- Natural sub-module `sat_counter`:
  - Ports: `CNT_W`, `inc`, `clr`.
  - Saturating, synchronous active-high reset.
  - Instantiated for `edge_cnt`; reusable by other CDC blocks.

## Test plan
- `STABLE_CYCLES`=4, `CNT_W`=4. Reset, then hold `d_sync`=1 from cycle 0 → `q`=1 and `rise`=1 after the 4th edge; `rise` low next cycle; `edge_cnt`=1.
- Toggle `d_sync` every cycle for 12 cycles from `LOW` → `q`=0, `rise`=`fall`=0, `edge_cnt`=0 throughout.
- `d_sync`=1 for 3 cycles then 0; later 1 for 4 cycles → no edge after the 3-cycle burst; `rise` after the 4th cycle of the second burst.
- 20 accepted alternating edges (each level held ≥4 cycles) → `edge_cnt` reaches 15 and holds at 15.
- Assert `cnt_clr` on the cycle `fall` is produced, with `edge_cnt`=9 → `edge_cnt`=1.
- `d_sync`=1 for 3 cycles, then `rst` for 1 cycle, `d_sync` still 1 → all outputs 0 after reset; `rise` only after 4 further cycles.
